// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Multicycle FSM controller for a MIPS-subset core (R-type
//            ADD/SUB/AND/OR/SLT, ADDI, LW, SW, BEQ, J). Sequences
//            fetch/decode/execute/memory/writeback, waits on a memory ready
//            handshake with timeout, traps on illegal encodings and counts
//            retired instructions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   run                  leave IDLE and start fetching
//   op_code, func_code   decode fields from the instruction register
//   mem_ready            memory completes the current access this cycle
//   alu_zero             ALU zero flag, consumed in the branch cycle
//   trap_clr             leave TRAP and return to IDLE
//   ALU_OP               AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111
//   Branch, CNTRL_RS, MEM_WS, MEM_RS, MEM_TR, PC_WE, IR_WE, Jump
//                        datapath / memory / PC control strobes
//   instr_done           pulse on the final cycle of each instruction
//   trap, trap_cause     sticky trap flag and cause (01 illegal, 10 timeout)
//   ret_cnt              retired instruction counter (wraps)
// ============================================================================
module multicycle_control_unit #(
  parameter int OP_W        = 6,
  parameter int FUNC_W      = 6,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OP_W-1:0]     op_code,
  input  logic [FUNC_W-1:0]   func_code,
  input  logic                mem_ready,
  input  logic                alu_zero,
  input  logic                trap_clr,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                Branch,
  output logic                CNTRL_RS,
  output logic                MEM_WS,
  output logic                MEM_RS,
  output logic                MEM_TR,
  output logic                PC_WE,
  output logic                IR_WE,
  output logic                Jump,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    ret_cnt
);

  // State encoding
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_WB_ALU = 4'd5;
  localparam logic [3:0] S_ADDR   = 4'd6;
  localparam logic [3:0] S_MEM_RD = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_MEM_WR = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [OP_W-1:0] C_OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] C_OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] C_OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] C_OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] C_OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] C_OP_J     = OP_W'(6'b000010);

  localparam logic [FUNC_W-1:0] C_FN_ADD = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] C_FN_SUB = FUNC_W'(6'b100010);
  localparam logic [FUNC_W-1:0] C_FN_AND = FUNC_W'(6'b100100);
  localparam logic [FUNC_W-1:0] C_FN_OR  = FUNC_W'(6'b100101);
  localparam logic [FUNC_W-1:0] C_FN_SLT = FUNC_W'(6'b101010);

  localparam logic [ALU_OP_W-1:0] C_ALU_AND = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] C_ALU_OR  = ALU_OP_W'(4'b0001);
  localparam logic [ALU_OP_W-1:0] C_ALU_ADD = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] C_ALU_SUB = ALU_OP_W'(4'b0110);
  localparam logic [ALU_OP_W-1:0] C_ALU_SLT = ALU_OP_W'(4'b0111);

  localparam logic [1:0] C_CAUSE_NONE = 2'b00;
  localparam logic [1:0] C_CAUSE_ILL  = 2'b01;
  localparam logic [1:0] C_CAUSE_MEM  = 2'b10;

  // The wait counter reaches MEM_TIMEOUT on the same edge that leaves for
  // TRAP, so the decision is taken while it still holds MEM_TIMEOUT-1.
  localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0]          r_state;
  logic [3:0]          w_next;
  logic [7:0]          r_wait;
  logic                r_trap;
  logic [1:0]          r_trap_cause;
  logic [1:0]          w_cause_next;
  logic [CNT_W-1:0]    r_ret;
  logic [ALU_OP_W-1:0] r_alu_hold;
  logic [ALU_OP_W-1:0] w_func_alu;
  logic                w_func_legal;
  logic                w_wait_state;
  logic                w_timeout;

  // R-type function decode
  always_comb begin
    w_func_alu   = C_ALU_ADD;
    w_func_legal = 1'b1;
    case (func_code)
      C_FN_ADD: w_func_alu = C_ALU_ADD;
      C_FN_SUB: w_func_alu = C_ALU_SUB;
      C_FN_AND: w_func_alu = C_ALU_AND;
      C_FN_OR:  w_func_alu = C_ALU_OR;
      C_FN_SLT: w_func_alu = C_ALU_SLT;
      default:  w_func_legal = 1'b0;
    endcase
  end

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
  // A late mem_ready on the final allowed cycle still wins over the timeout.
  assign w_timeout    = w_wait_state && !mem_ready && (r_wait == C_WAIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next       = r_state;
    w_cause_next = C_CAUSE_NONE;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = C_CAUSE_MEM;
        end
      end
      S_DECODE: begin
        case (op_code)
          C_OP_RTYPE: begin
            if (w_func_legal) begin
              w_next = S_EXEC_R;
            end else begin
              w_next       = S_TRAP;
              w_cause_next = C_CAUSE_ILL;
            end
          end
          C_OP_ADDI: w_next = S_EXEC_I;
          C_OP_LW:   w_next = S_ADDR;
          C_OP_SW:   w_next = S_ADDR;
          C_OP_BEQ:  w_next = S_BRANCH;
          C_OP_J:    w_next = S_JUMP;
          default: begin
            w_next       = S_TRAP;
            w_cause_next = C_CAUSE_ILL;
          end
        endcase
      end
      S_EXEC_R: w_next = S_WB_ALU;
      S_EXEC_I: w_next = S_WB_ALU;
      S_WB_ALU: w_next = S_FETCH;
      S_ADDR:   w_next = (op_code == C_OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) begin
          w_next = S_WB_MEM;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = C_CAUSE_MEM;
        end
      end
      S_WB_MEM: w_next = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = C_CAUSE_MEM;
        end
      end
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP: begin
        if (trap_clr) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ALU_OP     = '0;
    Branch     = 1'b0;
    CNTRL_RS   = 1'b0;
    MEM_WS     = 1'b0;
    MEM_RS     = 1'b0;
    MEM_TR     = 1'b0;
    PC_WE      = 1'b0;
    IR_WE      = 1'b0;
    Jump       = 1'b0;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        MEM_RS = 1'b1;
        ALU_OP = C_ALU_ADD;
        if (mem_ready) begin
          IR_WE = 1'b1;
          PC_WE = 1'b1;
        end
      end
      S_DECODE: ALU_OP = C_ALU_ADD;
      S_EXEC_R: ALU_OP = w_func_alu;
      S_EXEC_I: ALU_OP = C_ALU_ADD;
      S_WB_ALU: begin
        ALU_OP     = r_alu_hold;
        CNTRL_RS   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDR:   ALU_OP = C_ALU_ADD;
      S_MEM_RD: MEM_RS = 1'b1;
      S_WB_MEM: begin
        MEM_TR     = 1'b1;
        CNTRL_RS   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MEM_WS     = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALU_OP     = C_ALU_SUB;
        Branch     = 1'b1;
        PC_WE      = alu_zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        Jump       = 1'b1;
        PC_WE      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory wait counter: restarts whenever the state changes, so every
  // entry into a wait state begins from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= 8'd0;
    end else if (w_next != r_state) begin
      r_wait <= 8'd0;
    end else if (w_wait_state && !mem_ready) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  // Sticky trap flag and cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap       <= 1'b0;
      r_trap_cause <= C_CAUSE_NONE;
    end else if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
      r_trap       <= 1'b1;
      r_trap_cause <= w_cause_next;
    end else if ((r_state == S_TRAP) && trap_clr) begin
      r_trap       <= 1'b0;
      r_trap_cause <= C_CAUSE_NONE;
    end
  end

  // Retired counter, plus the ALU code of the execute cycle so writeback can
  // keep presenting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret      <= '0;
      r_alu_hold <= '0;
    end else begin
      r_alu_hold <= ALU_OP;
      if (instr_done) r_ret <= r_ret + CNT_W'(1);
    end
  end

  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;
  assign ret_cnt    = r_ret;

endmodule
`default_nettype wire
